dmem_responder: RTL
===================

// Module: dmem_responder
// PURPOSE
//  Multi-cycle data-memory responder that serves load/store requests issued by the
//  pipelined datapath's MEMORY stage.
//  Adds configurable wait states, word/byte access and error reporting.
//  Drives a stall back to the pipeline while a request is outstanding.
//  Sits between the EM/MW pipeline registers in place of a zero-latency memory.
// PARAMETERS
//  DEPTH        64  number of 32-bit words stored (power of 2, >= 4)
//  WAIT_CYCLES  2   extra wait states per access (0..15)
// PORTS
//  clk        in   1   single clock, all state updates on rising edge
//  reset      in   1   synchronous, active-high
//  req_valid  in   1   MEMORY stage holds a load/store request
//  req_write  in   1   1 = store, 0 = load
//  req_byte   in   1   1 = byte access (LDRB/STRB), 0 = word access
//  req_addr   in   32  byte address (ALUOutM)
//  req_wdata  in   32  store data (WriteDataM); byte store uses bits [7:0]
//  req_ready  out  1   responder can accept a request this cycle
//  rsp_valid  out  1   one-cycle pulse: access complete, rsp_rdata/rsp_err valid
//  rsp_rdata  out  32  load data (zero for stores and errors)
//  rsp_err    out  1   access was out of range or misaligned
//  stall      out  1   pipeline must hold F/D/E/M stages this cycle
// BEHAVIOUR
//  - Reset: one clock with reset=1 forces
//    state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
//    Memory array is not cleared.
//  - FSM states: IDLE, WAIT, RESP.
//  - IDLE: req_ready=1. Accept when req_valid=1 at a rising edge.
//    Latch addr, wdata, write, byte at that edge.
//    If WAIT_CYCLES=0, perform the access at that edge and go to RESP.
//    Otherwise load cnt=WAIT_CYCLES-1 and go to WAIT.
//  - WAIT: req_ready=0. If cnt!=0, decrement cnt. If cnt==0, perform the access
//    and go to RESP.
//  - RESP: req_ready=0, rsp_valid=1 for exactly one cycle; next edge returns to IDLE.
//  - Latency: rsp_valid is high WAIT_CYCLES+1 cycles after the accept cycle.
//    Throughput: one request per WAIT_CYCLES+2 cycles.
//  - stall = (IDLE & req_valid) | WAIT. stall=0 in RESP so the pipeline advances and
//    captures rsp_rdata. A new request in the following cycle is accepted in IDLE.
//  - Access performed at the edge leaving WAIT, or at the accept edge when WAIT_CYCLES=0:
//    word index = addr[log2(DEPTH)+1:2]; byte lane = addr[1:0], little-endian.
//  - Error if addr >= DEPTH*4, or if word access has addr[1:0]!=0:
//    no array write, rsp_rdata=0, rsp_err=1.
//  - Word load: rsp_rdata = mem[idx]. Byte load: rsp_rdata = {24'b0, selected lane}.
//  - Word store: mem[idx]=wdata. Byte store: only the selected lane gets wdata[7:0];
//    other lanes unchanged. Stores return rsp_rdata=0, rsp_err=0.
//  - rsp_rdata/rsp_err are registered and hold their value until the next access
//    completes. They are valid only while rsp_valid=1.
//  - Request inputs are sampled only at the accept edge; later changes are ignored.
//  - Reset mid-operation (WAIT or RESP): the pending access is dropped, no array
//    write occurs, rsp_valid does not pulse, and the FSM returns to IDLE next cycle.
//  - req_valid with req_ready=0 is ignored (no queueing).
// TESTING
//  1. WAIT_CYCLES=2: store word 0xDEADBEEF @0x10, then load @0x10 ->
//     stall high 3 cycles each; rsp_valid 3 cycles after accept; rdata=0xDEADBEEF, err=0.
//  2. Byte store 0xAB @0x13 over word 0x11223344 @0x10, then word load @0x10 -> 0xAB223344.
//     Byte load @0x13 -> 0x000000AB.
//  3. Word load @0x12 -> rsp_err=1, rdata=0. Store @0x100 (DEPTH=64) -> rsp_err=1 and
//     the array is unchanged (verify by reading back every word).
//  4. WAIT_CYCLES=0: back-to-back loads @0x0, 0x4 -> each rsp_valid 1 cycle after accept;
//     stall pattern 1,0,1,0.
//  5. Store @0x8 with reset asserted while in WAIT -> no rsp_valid; state IDLE; mem[2]
//     retains its prior value.
//  6. Change req_addr/req_wdata during WAIT -> response reflects the latched values only.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder
//   Multi-cycle data-memory responder for the MEMORY stage. It accepts one
//   load/store at a time, inserts WAIT_CYCLES wait states, performs the access,
//   and then pulses rsp_valid for one cycle. While a request is outstanding it
//   holds the pipeline with stall.
//
// Parameters
//   DEPTH        number of 32-bit words (power of 2, >= 4)
//   WAIT_CYCLES  extra wait states per access (0..15)
//
// Ports
//   clk, reset       rising-edge clock, synchronous active-high reset
//   req_valid        MEMORY stage presents a request
//   req_write        1 = store, 0 = load
//   req_byte         1 = byte access, 0 = word access
//   req_addr         byte address
//   req_wdata        store data (byte store uses [7:0])
//   req_ready        responder is idle and will accept a request
//   rsp_valid        one-cycle completion pulse
//   rsp_rdata        load data (zero for stores and errors)
//   rsp_err          out-of-range or misaligned access
//   stall            hold F/D/E/M this cycle
module dmem_responder #(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic        req_byte,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        stall
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [31:0] LIMIT     = 32'(DEPTH * 4);
  localparam bit          ZERO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [3:0]  CNT_INIT  = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        write_q;
  logic        byte_q;

  logic [31:0] mem [DEPTH];

  // With no wait states the access happens on the accept edge itself, so it
  // must use the live request; otherwise it uses the values latched at accept.
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic          acc_write;
  logic          acc_byte;
  logic          acc_err;
  logic          do_access;
  logic          wr_en;
  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic [31:0]   rd_word;
  logic [7:0]    rd_byte;
  logic [31:0]   rd_shift;

  always_comb begin
    acc_addr  = ZERO_WAIT ? req_addr  : addr_q;
    acc_wdata = ZERO_WAIT ? req_wdata : wdata_q;
    acc_write = ZERO_WAIT ? req_write : write_q;
    acc_byte  = ZERO_WAIT ? req_byte  : byte_q;

    idx  = acc_addr[AW+1:2];
    lane = acc_addr[1:0];

    acc_err = (acc_addr >= LIMIT) || (!acc_byte && (lane != 2'b00));

    do_access = !reset &&
                ((ZERO_WAIT && (state == IDLE) && req_valid) ||
                 ((state == WAIT) && (cnt == 4'd0)));
    wr_en     = do_access && acc_write && !acc_err;

    rd_word  = mem[idx];
    rd_shift = rd_word >> {lane, 3'b000};
    rd_byte  = rd_shift[7:0];
  end

  assign req_ready = (state == IDLE);
  assign stall     = ((state == IDLE) && req_valid) || (state == WAIT);

  // Array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (acc_byte) begin
        mem[idx][{lane, 3'b000} +: 8] <= acc_wdata[7:0];
      end else begin
        mem[idx] <= acc_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;

      if (do_access) begin
        rsp_valid <= 1'b1;
        rsp_err   <= acc_err;
        if (acc_err || acc_write) begin
          rsp_rdata <= '0;
        end else if (acc_byte) begin
          rsp_rdata <= {24'b0, rd_byte};
        end else begin
          rsp_rdata <= rd_word;
        end
      end

      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            write_q <= req_write;
            byte_q  <= req_byte;
            cnt     <= CNT_INIT;
            state   <= ZERO_WAIT ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
